// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter: round-robin grant with stall lock onto one slave port,
// plus an ID FIFO that routes in-order slave responses back to the issuing channel.
module sram_like_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [NUM_CH-1:0]                 m_req_i,
  input  logic [NUM_CH-1:0]                 m_wr_i,
  input  logic [2*NUM_CH-1:0]               m_size_i,
  input  logic [ADDR_W*NUM_CH-1:0]          m_addr_i,
  input  logic [(DATA_W/8)*NUM_CH-1:0]      m_wstrb_i,
  input  logic [DATA_W*NUM_CH-1:0]          m_wdata_i,
  output logic [NUM_CH-1:0]                 m_addr_ok_o,
  output logic [NUM_CH-1:0]                 m_data_ok_o,
  output logic [DATA_W-1:0]                 m_rdata_o,
  output logic                              s_req_o,
  output logic                              s_wr_o,
  output logic [1:0]                        s_size_o,
  output logic [ADDR_W-1:0]                 s_addr_o,
  output logic [DATA_W/8-1:0]               s_wstrb_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  input  logic                              s_addr_ok_i,
  input  logic                              s_data_ok_i,
  input  logic [DATA_W-1:0]                 s_rdata_i,
  output logic                              err_unexp_o,
  output logic                              dbg_lock_o,
  output logic [$clog2(MAX_OUT+1)-1:0]      dbg_count_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int STB_W = DATA_W / 8;

  // Handshakes: a master address handshake is m_req & m_addr_ok, a slave address
  // handshake is s_req & s_addr_ok, and a response is the single-cycle s_data_ok pulse.
  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic [CH_W-1:0]    fifo_q [MAX_OUT];

  logic               gnt_vld;
  logic [CH_W-1:0]    gnt_idx;
  int                 scan_idx;
  logic               not_full;
  logic               slv_hs;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Descending scan so the channel closest at/after rr_ptr is the last (winning) write.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    if (state_q == ST_LOCKED) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_ch_q;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        scan_idx = (int'(rr_ptr_q) + k) % NUM_CH;
        if (m_req_i[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_W'(scan_idx);
        end
      end
    end
  end

  assign not_full = (count_q < CNT_W'(MAX_OUT));
  assign slv_hs   = s_req_o & s_addr_ok_i;
  assign pop      = s_data_ok_i & (count_q != '0) & ~reset_i;

  always_comb begin
    s_req_o     = 1'b0;
    s_wr_o      = 1'b0;
    s_size_o    = '0;
    s_addr_o    = '0;
    s_wstrb_o   = '0;
    s_wdata_o   = '0;
    m_addr_ok_o = '0;
    m_data_ok_o = '0;
    m_rdata_o   = '0;
    if (!reset_i) begin
      m_rdata_o = s_rdata_i;
      if (gnt_vld) begin
        s_req_o   = m_req_i[gnt_idx] & not_full;
        s_wr_o    = m_wr_i[gnt_idx];
        s_size_o  = m_size_i[gnt_idx*2 +: 2];
        s_addr_o  = m_addr_i[gnt_idx*ADDR_W +: ADDR_W];
        s_wstrb_o = m_wstrb_i[gnt_idx*STB_W +: STB_W];
        s_wdata_o = m_wdata_i[gnt_idx*DATA_W +: DATA_W];
        m_addr_ok_o[gnt_idx] = s_req_o & s_addr_ok_i;
      end
      m_data_ok_o[fifo_q[rd_ptr_q]] = pop;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    if (slv_hs) begin
      state_d  = ST_OPEN;
      rr_ptr_d = CH_W'((int'(gnt_idx) + 1) % NUM_CH);
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else if (s_req_o) begin
      // Slave stalled: pin the grant so the presented request stays stable.
      state_d   = ST_LOCKED;
      lock_ch_d = gnt_idx;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({slv_hs, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (s_data_ok_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_OPEN;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (slv_hs) begin
      fifo_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign err_unexp_o = err_q & ~reset_i;
  assign dbg_lock_o  = (state_q == ST_LOCKED) & ~reset_i;
  assign dbg_count_o = reset_i ? '0 : count_q;

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter that merges several SRAM-like master ports (req/wr/size/addr/wstrb/wdata with addr_ok/data_ok/rdata) onto one SRAM-like slave port. It sits between the CPU core's instruction/data SRAM-like ports and the single memory-side SRAM-like bridge. It supports any channel count, round-robin fairness, up to MAX_OUT in-flight transactions, and in-order routing of responses back to the issuing channel.

## Interface
- NUM_CH, 2, number of master channels (2..8); channel 0 is the instruction port by convention
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- MAX_OUT, 4, max accepted-but-unanswered transactions (power of 2, 1..16)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m_req  in  NUM_CH  per-channel request
- m_wr  in  NUM_CH  per-channel write flag
- m_size  in  2*NUM_CH  per-channel size (0=byte, 1=half, 2=word); channel i in bits [2i+1:2i]
- m_addr  in  ADDR_W*NUM_CH  per-channel address, packed the same way
- m_wstrb  in  (DATA_W/8)*NUM_CH  per-channel byte strobes
- m_wdata  in  DATA_W*NUM_CH  per-channel write data
- m_addr_ok  out  NUM_CH  request accepted, one-hot or zero
- m_data_ok  out  NUM_CH  response valid, one-hot or zero
- m_rdata  out  DATA_W  read data, broadcast to all channels; valid only where m_data_ok is set
- s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata  out  1/1/2/ADDR_W/DATA_W/8/DATA_W  slave request from the granted channel
- s_addr_ok  in  1  slave accepted the request
- s_data_ok  in  1  slave response, in order
- s_rdata  in  DATA_W  slave read data
- err_unexp  out  1  sticky: s_data_ok was seen while no transaction was outstanding

## Operation
- **Handshakes.**
  - An address handshake on channel i is m_req[i] & m_addr_ok[i].
  - A slave address handshake is s_req & s_addr_ok.
  - A slave data handshake is s_data_ok.
- **Grant selection.**
  - If lock=1, grant = lock_ch.
  - Otherwise grant is the first requesting channel at or after rr_ptr, searching in increasing index and wrapping at NUM_CH.
  - With no requests, grant is none.
- **Slave request.** s_req = m_req[grant] & (count < MAX_OUT) & ~reset. All other s_* fields are a combinational mux of the granted channel.
  - With no grant, s_req = 0 and the other fields are 0.
- **Address ok.** m_addr_ok[grant] = s_addr_ok & s_req. All other m_addr_ok bits are 0.
- **Grant lock.**
  - If s_req & ~s_addr_ok: lock <= 1 and lock_ch <= grant. This keeps the request stable until accepted, as the SRAM-like protocol requires.
  - On a slave address handshake: lock <= 0.
- **Round-robin pointer.** On a slave address handshake, rr_ptr <= (grant+1) mod NUM_CH.
- **ID FIFO.** Depth MAX_OUT, storing channel index (clog2(NUM_CH) bits), with count 0..MAX_OUT.
  - Pushes the granted index on a slave address handshake.
  - Pops on s_data_ok when count>0.
  - Push and pop in the same cycle leave count unchanged.
- **Response routing.**
  - m_data_ok[head] = s_data_ok & (count>0). All other bits are 0.
  - m_rdata = s_rdata.
- **Unexpected response.** s_data_ok with count==0 routes to no channel and sets err_unexp. err_unexp clears only on reset.
- **Full.** When count==MAX_OUT, s_req is held 0 and m_addr_ok is 0. Lock state is kept.
- **Request withdrawal.** A master dropping m_req while locked violates protocol; lock still clears on the next s_addr_ok or on reset.
- **Reset.**
  - Asserting reset in any cycle clears rr_ptr=0, lock=0, count=0, FIFO pointers=0, and err_unexp=0.
  - While reset=1, all outputs are 0.
  - In-flight transactions are discarded; a late s_data_ok after reset sets err_unexp.

## Timing
- Request path is combinational, with zero added latency: m_req to s_req, and s_addr_ok to m_addr_ok.
- Response path is combinational: s_data_ok/s_rdata to m_data_ok/m_rdata in the same cycle.
- An entry pushed in cycle t can be popped by s_data_ok in cycle t+1 at the earliest. A same-cycle push+pop when count==0 does not bypass.
- Throughput is one address handshake per cycle, and one response per cycle.
- Grant lock and rr_ptr take effect the cycle after the condition that sets them.

## Test plan
- **Single channel read.** NUM_CH=2, ch1 issues a read of 0x1000 with s_addr_ok=1 immediately and s_data_ok 3 cycles later with rdata 0xDEADBEEF. Required: m_addr_ok=2'b10 in cycle 0, then m_data_ok=2'b10 and m_rdata=0xDEADBEEF in cycle 3.
- **Round-robin fairness.** Both channels hold m_req continuously with s_addr_ok=1. Required: grants alternate 0,1,0,1 after reset; FIFO order matches, and responses return ok bits 01,10,01,10.
- **Lock under stall.** ch0 requests, s_addr_ok=0 for 4 cycles, ch1 raises m_req in cycle 1. Required: s_addr stays on ch0's address for all 4 cycles; after s_addr_ok, ch1 is granted next.
- **Full.** MAX_OUT=4, five back-to-back accepted requests with no s_data_ok. Required: the 5th sees s_req=0 until the first s_data_ok; a pop in cycle t lets the request through in cycle t+1.
- **Simultaneous push/pop and reset mid-flight.** With count=2, a push and pop in the same cycle leave count=2. Then reset is asserted. Required: all outputs are 0 during reset; a subsequent s_data_ok routes nowhere and sets err_unexp=1.
